// File: rtl/secded_scrub_counter_pkg.sv
// Shared types and per-nibble SECDED helpers for the scrubbed counter.
// Each nibble carries Hamming(7,4) check bits plus an overall parity bit.
package secded_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StCheck,
      StWriteback,
      StFault
   } state_e;

   // Syndrome {s2,s1,s0} produced by a single flipped bit in each position.
   localparam logic [2:0] SynNone = 3'b000;
   localparam logic [2:0] SynD0   = 3'b111;
   localparam logic [2:0] SynD1   = 3'b011;
   localparam logic [2:0] SynD2   = 3'b101;
   localparam logic [2:0] SynD3   = 3'b110;
   localparam logic [2:0] SynP0   = 3'b001;
   localparam logic [2:0] SynP1   = 3'b010;
   localparam logic [2:0] SynP2   = 3'b100;

   typedef struct packed {
      logic [3:0] data;
      logic [3:0] chk;
      logic       ce;
      logic       ue;
   } nibble_dec_t;

   function automatic logic [3:0] encode_nibble(input logic [3:0] d);
      return {d[1] ^ d[2] ^ d[3],
              d[0] ^ d[2] ^ d[3],
              d[0] ^ d[1] ^ d[3],
              d[0] ^ d[1] ^ d[2]};
   endfunction

   function automatic nibble_dec_t decode_nibble(input logic [3:0] data, input logic [3:0] chk);
      nibble_dec_t res;
      logic [2:0]  syn;
      logic        odd;
      syn = 3'(encode_nibble(data) ^ chk);
      odd = ^{data, chk};
      res = '{data: data, chk: chk, ce: 1'b0, ue: 1'b0};
      if (odd) begin
         res.ce = 1'b1;
         case (syn)
            SynD0:   res.data[0] = ~data[0];
            SynD1:   res.data[1] = ~data[1];
            SynD2:   res.data[2] = ~data[2];
            SynD3:   res.data[3] = ~data[3];
            SynP0:   res.chk[0]  = ~chk[0];
            SynP1:   res.chk[1]  = ~chk[1];
            SynP2:   res.chk[2]  = ~chk[2];
            default: res.chk[3]  = ~chk[3];
         endcase
      end else if (syn != SynNone) begin
         res.ue = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/secded_scrub_counter_if.sv
// Control, injection and status bundle between the counter and its user.
interface secded_scrub_counter_if #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned ERR_CNT_W = 8
);
   localparam int unsigned CHK_BITS = (WIDTH / 4) * 4;

   logic                 enable;
   logic                 clear;
   logic                 inj_valid;
   logic [WIDTH-1:0]     inj_data_mask;
   logic [CHK_BITS-1:0]  inj_chk_mask;
   logic [WIDTH-1:0]     counter;
   logic                 busy;
   logic                 ce_pulse;
   logic                 ue_pulse;
   logic                 ue_sticky;
   logic [ERR_CNT_W-1:0] ce_count;
   logic [ERR_CNT_W-1:0] ue_count;

   modport master (
      output enable, clear, inj_valid, inj_data_mask, inj_chk_mask,
      input  counter, busy, ce_pulse, ue_pulse, ue_sticky, ce_count, ue_count
   );

   modport slave (
      input  enable, clear, inj_valid, inj_data_mask, inj_chk_mask,
      output counter, busy, ce_pulse, ue_pulse, ue_sticky, ce_count, ue_count
   );

endinterface

// File: rtl/secded_scrub_counter_codec.sv
// Word-wide SECDED codec: decodes the stored word and encodes the word being written.
module secded_word_codec
   import secded_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] rd_data,
   input  logic [WIDTH-1:0] rd_chk,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] cor_data,
   output logic [WIDTH-1:0] cor_chk,
   output logic [WIDTH-1:0] wr_chk,
   output logic             ce,
   output logic             ue
);
   localparam int unsigned BLOCKS = WIDTH / 4;

   nibble_dec_t dec;
   logic        ce_any;

   always_comb begin
      cor_data = '0;
      cor_chk  = '0;
      wr_chk   = '0;
      dec      = '0;
      ce_any   = 1'b0;
      ue       = 1'b0;
      for (int i = 0; i < BLOCKS; i++) begin
         dec                  = decode_nibble(rd_data[4*i +: 4], rd_chk[4*i +: 4]);
         cor_data[4*i +: 4]   = dec.data;
         cor_chk[4*i +: 4]    = dec.chk;
         ce_any               = ce_any | dec.ce;
         ue                   = ue | dec.ue;
         wr_chk[4*i +: 4]     = encode_nibble(wr_data[4*i +: 4]);
      end
      // Any uncorrectable block makes the whole word uncorrectable.
      ce = ce_any & ~ue;
   end

endmodule

// File: rtl/secded_scrub_counter.sv
// Free-running counter with per-nibble SECDED storage, correct-on-increment,
// periodic idle scrubbing, saturating error statistics and error injection.
module secded_scrub_counter
   import secded_pkg::*;
#(
   parameter int unsigned WIDTH          = 64,
   parameter int unsigned SCRUB_INTERVAL = 16,
   parameter int unsigned ERR_CNT_W      = 8
) (
   input logic                   clk,
   input logic                   rst,
   secded_scrub_counter_if.slave bus
);
   localparam int unsigned BLOCKS   = WIDTH / 4;
   localparam int unsigned CHK_BITS = BLOCKS * 4;
   localparam int unsigned TIMER_W  = $clog2(SCRUB_INTERVAL);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCRUB_INTERVAL - 1);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     data_q, data_d, scrub_data_q, scrub_data_d;
   logic [CHK_BITS-1:0]  chk_q, chk_d, scrub_chk_q, scrub_chk_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [1:0]           pend_q, pend_d;
   logic [ERR_CNT_W-1:0] ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
   logic                 sticky_q, sticky_d;
   logic                 ue_pulse_q, ue_pulse_d;
   logic                 ce_pulse;

   logic [WIDTH-1:0]     cor_data, wr_data;
   logic [CHK_BITS-1:0]  cor_chk, wr_chk;
   logic                 dec_ce, dec_ue;
   logic [2:0]           inc;

   // Held increments plus this cycle's request are applied in one write.
   assign inc     = {1'b0, pend_q} + {2'b00, bus.enable};
   assign wr_data = cor_data + WIDTH'(inc);

   secded_word_codec #(
      .WIDTH (WIDTH)
   ) u_codec (
      .rd_data  (data_q),
      .rd_chk   (chk_q),
      .wr_data  (wr_data),
      .cor_data (cor_data),
      .cor_chk  (cor_chk),
      .wr_chk   (wr_chk),
      .ce       (dec_ce),
      .ue       (dec_ue)
   );

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      chk_d        = chk_q;
      scrub_data_d = scrub_data_q;
      scrub_chk_d  = scrub_chk_q;
      timer_d      = timer_q;
      pend_d       = pend_q;
      ce_cnt_d     = ce_cnt_q;
      ue_cnt_d     = ue_cnt_q;
      sticky_d     = sticky_q;
      ue_pulse_d   = 1'b0;
      ce_pulse     = 1'b0;

      case (state_q)
         StIdle, StRun: begin
            if (dec_ue) begin
               state_d = StFault;
               timer_d = '0;
            end else begin
               if (inc != 3'd0) begin
                  data_d   = wr_data;
                  chk_d    = wr_chk;
                  pend_d   = 2'd0;
                  ce_pulse = dec_ce;
               end
               if (bus.enable) begin
                  timer_d = '0;
                  state_d = StRun;
               end else if (timer_q == TIMER_LAST) begin
                  timer_d = '0;
                  state_d = StCheck;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
                  state_d = StIdle;
               end
            end
         end
         StCheck: begin
            scrub_data_d = cor_data;
            scrub_chk_d  = cor_chk;
            if (bus.enable && pend_q != 2'b11) pend_d = pend_q + 2'd1;
            if (dec_ue)      state_d = StFault;
            else if (dec_ce) state_d = StWriteback;
            else             state_d = bus.enable ? StRun : StIdle;
         end
         StWriteback: begin
            data_d   = scrub_data_q;
            chk_d    = scrub_chk_q;
            ce_pulse = 1'b1;
            if (bus.enable && pend_q != 2'b11) pend_d = pend_q + 2'd1;
            state_d  = bus.enable ? StRun : StIdle;
         end
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase

      if (ce_pulse && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + ERR_CNT_W'(1);

      if (state_d == StFault && state_q != StFault) begin
         ue_pulse_d = 1'b1;
         sticky_d   = 1'b1;
         if (ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + ERR_CNT_W'(1);
      end

      if (bus.inj_valid) begin
         data_d = data_d ^ bus.inj_data_mask;
         chk_d  = chk_d ^ bus.inj_chk_mask;
      end

      // encode(0) is all zeros, so a cleared word is already consistent.
      if (bus.clear) begin
         state_d    = StIdle;
         data_d     = '0;
         chk_d      = '0;
         timer_d    = '0;
         pend_d     = 2'd0;
         ce_cnt_d   = '0;
         ue_cnt_d   = '0;
         sticky_d   = 1'b0;
         ue_pulse_d = 1'b0;
         ce_pulse   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         data_q       <= '0;
         chk_q        <= '0;
         scrub_data_q <= '0;
         scrub_chk_q  <= '0;
         timer_q      <= '0;
         pend_q       <= 2'd0;
         ce_cnt_q     <= '0;
         ue_cnt_q     <= '0;
         sticky_q     <= 1'b0;
         ue_pulse_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         chk_q        <= chk_d;
         scrub_data_q <= scrub_data_d;
         scrub_chk_q  <= scrub_chk_d;
         timer_q      <= timer_d;
         pend_q       <= pend_d;
         ce_cnt_q     <= ce_cnt_d;
         ue_cnt_q     <= ue_cnt_d;
         sticky_q     <= sticky_d;
         ue_pulse_q   <= ue_pulse_d;
      end
   end

   assign bus.counter   = cor_data;
   assign bus.busy      = (state_q == StCheck) || (state_q == StWriteback) ||
                          (state_q == StFault);
   assign bus.ce_pulse  = ce_pulse;
   assign bus.ue_pulse  = ue_pulse_q;
   assign bus.ue_sticky = sticky_q;
   assign bus.ce_count  = ce_cnt_q;
   assign bus.ue_count  = ue_cnt_q;

endmodule

// File: doc/secded_scrub_counter.md
Name: secded_scrub_counter

Overview:
- Free-running up-counter whose state register is protected by per-nibble SECDED: Hamming(7,4) plus an overall parity bit, 4 check bits per 4 data bits.
- Parametrised successor of the single-error Hamming counter. Adds double-error detection, correction on every increment, periodic idle scrubbing, error statistics, and a test error-injection port.
- Sits in the counter datapath. Status outputs feed the reliability monitor.

Parameters:
- WIDTH, 64, counter data width; must be a multiple of 4 and ≥ 8.
- BLOCKS, WIDTH/4, number of protected nibbles (derived).
- CHK_BITS, BLOCKS*4, total stored check bits (derived).
- SCRUB_INTERVAL, 16, idle cycles between scrubs; ≥ 2.
- ERR_CNT_W, 8, width of the saturating error counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  count request; counter advances once per cycle while high
- clear  in  1  synchronous clear of counter, check bits, statistics and sticky flag
- inj_valid  in  1  one-cycle error-injection strobe
- inj_data_mask  in  WIDTH  XOR mask applied to stored data on inj_valid
- inj_chk_mask  in  CHK_BITS  XOR mask applied to stored check bits on inj_valid
- counter  out  WIDTH  corrected counter value (combinational decode of stored word)
- busy  out  1  high in CHECK, WRITEBACK and FAULT
- ce_pulse  out  1  one-cycle pulse per correctable event
- ue_pulse  out  1  one-cycle pulse on uncorrectable detection
- ue_sticky  out  1  latched uncorrectable flag
- ce_count  out  ERR_CNT_W  saturating count of correctable events
- ue_count  out  ERR_CNT_W  saturating count of uncorrectable events

Behaviour:
- Reset (rst=0, async) clears: data, check bits, statistics, sticky flag, pending count and scrub timer. Outputs: counter=0, busy=0, all pulses 0, ue_sticky=0. State = IDLE.
- Encoding, per block i, with d0..d3 = data[4i+0..3]:
  - p0 = d0^d1^d2, p1 = d0^d1^d3, p2 = d0^d2^d3, p3 = d1^d2^d3 (overall parity of the 7-bit codeword).
  - Stored layout: chk[4i+3:4i] = {p3,p2,p1,p0}.
  - Every write re-encodes, so a clean word always has zero syndrome.
- Decode, per block:
  - s = {s2,s1,s0} = recomputed ^ stored p2..p0; o = XOR of all 8 stored bits.
  - Single-error syndrome map: 111→d0, 011→d1, 101→d2, 110→d3, 001→p0, 010→p1, 100→p2.
  - s≠0 with o=1 → correctable (CE), flip the indicated bit.
  - s=0 with o=1 → CE in p3.
  - s≠0 with o=0 → uncorrectable (UE).
  - Word-level CE if any block is CE and none is UE; UE if any block is UE.
- FSM states: IDLE, RUN, CHECK, WRITEBACK, FAULT.
  - IDLE and RUN differ only by enable. Each enabled cycle writes corrected+1 (read-correct-modify-write). A CE on that read raises ce_pulse in the same cycle as the write. Wraps from all-ones to 0.
  - IDLE with enable=0: scrub timer counts to SCRUB_INTERVAL-1, then → CHECK. The timer resets on any enabled cycle.
  - CHECK (1 cycle) registers the decode. Clean → IDLE. CE → WRITEBACK. UE → FAULT.
  - WRITEBACK (1 cycle) writes the corrected word, pulses ce_pulse, → IDLE/RUN.
  - Increments requested during CHECK/WRITEBACK are held in a 2-bit pending count. On exit, the first write adds pend + (enable?1:0). No count is lost.
  - UE seen in any state → FAULT. In FAULT: ue_pulse in the entry cycle, ue_sticky=1, ue_count+1, data frozen, enable ignored, busy=1. Only clear or reset leaves FAULT.
- clear: next cycle data=0, check bits=encode(0), statistics=0, sticky=0, pend=0, state=IDLE. clear has priority over enable and over injection.
- Injection: the stored value becomes (value written this cycle, or held value) XOR mask. It does not itself raise pulses; detection occurs on the next read or scrub.
- ce_count/ue_count saturate at all-ones.
- Reset mid-CHECK/WRITEBACK: state is discarded, no writeback occurs, all values return to reset state.

Decomposition:
- Shared package secded_pkg holds:
  - state enum;
  - syndrome constants;
  - functions encode_nibble (4→4) and decode_nibble (data + chk → corrected data, corrected chk, ce, ue).
- One sub-module, secded_word_codec: combinational BLOCKS-wide encode/decode, reused for both the increment path and the scrub path.

Test Plan:
- Reset, enable high for 5 cycles → counter=5; chk equals encode(5); ce_count=0, busy=0.
- Idle, inject inj_data_mask bit 9 → after ≤SCRUB_INTERVAL+1 cycles CHECK then WRITEBACK; one ce_pulse; ce_count=1; counter still shows the correct value throughout.
- Counter=3, inject bits 0 and 1 of block 0 (double error) → ue_pulse once; ue_sticky=1; ue_count=1; counter frozen under enable. Then clear → counter=0, sticky=0, counting resumes.
- Hold enable high across an in-progress CHECK+WRITEBACK (enable rising during CHECK) → final count equals the number of enabled cycles; no increments dropped.
- WIDTH=8, preload 255 via enable run, one more enable → counter=0, chk=encode(0).
- Assert rst low during WRITEBACK after a single-bit inject → all outputs 0, state IDLE; no ce_pulse.
